accel_chip_seq: RTL and testbench
=================================

ACCEL_CHIP_SEQ -- requirements
Module: accel_chip_seq

Interface
REQ-001 The block SHALL have parameter NARRAY, default 4, meaning the number of array output bits on bit_out and rsp_data.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the width of addr_col and addr_row.
REQ-003 The block SHALL have parameter SETUP_CYC, default 2 (legal >=1), meaning cycles that address/instruction are held before any pulse.
REQ-004 The block SHALL have parameter PULSE_CYC, default 4 (legal >=1), meaning the width in cycles of CWL/CSL pulses.
REQ-005 The block SHALL have parameter HOLD_CYC, default 1 (legal >=0), meaning settle cycles after the pulse, before sampling.
REQ-006 The block SHALL have port clk_sys_in, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst_sys_in, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have cmd_valid/cmd_ready, input/output, 1 bit each: command handshake.
REQ-009 The block SHALL have cmd_op, input, 2 bits: 11 form/prog, 10 read_mem, 01 read_reg, 00 inference.
REQ-010 The block SHALL have cmd_col and cmd_row, inputs, ADDR_W bits each: target address.
REQ-011 The block SHALL have cmd_wbit, input, 1 bit: the value to program for op 11.
REQ-012 The block SHALL have rsp_valid/rsp_ready, output/input, 1 bit each: response handshake.
REQ-013 The block SHALL have rsp_data, output, NARRAY bits: sampled array bits.
REQ-014 The block SHALL have busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have the chip-side ports CBL, CBLEN, CSL, CWL, outputs, 1 bit each; instructions, output, 2 bits; addr_col and addr_row, outputs, ADDR_W bits each; bit_out, input, NARRAY bits, asynchronous to clk_sys_in.

Function
REQ-016 The block SHALL implement the states IDLE, SETUP, PULSE, HOLD, SAMPLE and RESP.
REQ-017 cmd_ready SHALL be high only in IDLE; a command SHALL be accepted on a cycle where cmd_valid && cmd_ready, and that cycle is cycle 0.
REQ-018 On accept, the block SHALL register op, col, row and wbit onto instructions, addr_col and addr_row, which SHALL hold steady until RESP is left.
REQ-019 SETUP SHALL last exactly SETUP_CYC cycles, with all pulse lines low.
REQ-020 PULSE SHALL last exactly PULSE_CYC cycles; pulse lines SHALL be driven only in PULSE.
REQ-021 In PULSE, op 11 SHALL drive CWL=1, CSL=1, CBLEN=1 and CBL=wbit.
REQ-022 In PULSE, op 10 SHALL drive CWL=1, CSL=1 and CBLEN=0.
REQ-023 In PULSE, op 00 SHALL drive CSL=1 only.
REQ-024 Op 01 SHALL skip PULSE and go from SETUP directly to HOLD or SAMPLE.
REQ-025 HOLD SHALL last HOLD_CYC cycles; if HOLD_CYC=0, HOLD SHALL be skipped.
REQ-026 SAMPLE SHALL last 1 cycle and SHALL capture bit_out (or its synchronised version) into rsp_data.
REQ-027 For op 11, rsp_data SHALL be 0 and a response SHALL still be issued.
REQ-028 RESP SHALL assert rsp_valid, holding it and rsp_data stable until rsp_ready; on rsp_valid && rsp_ready the block SHALL go to IDLE, with cmd_ready high the next cycle (no back-to-back overlap).
REQ-029 rsp_valid SHALL first be high at cycle SETUP_CYC + P + HOLD_CYC + 2 (+2 with sync, see Configuration), where P is PULSE_CYC, or 0 for op 01.
REQ-030 A cmd_valid in a non-IDLE state SHALL be ignored and not queued.
REQ-031 The phase counter SHALL be wide enough for max(SETUP_CYC, PULSE_CYC, HOLD_CYC+2) and SHALL never wrap inside a phase.

Reset
REQ-032 rst_sys_in asserted in any state, including mid-PULSE, SHALL force IDLE at the next edge.
REQ-033 During and after reset: CBL=CBLEN=CSL=CWL=0, instructions=01, addr_col=addr_row=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1 after release.
REQ-034 An interrupted command SHALL produce no response.

Configuration
REQ-035 With macro ACCEL_CHIP_SEQ_SYNC_EN defined, bit_out SHALL pass through a 2-flop synchroniser, HOLD SHALL be extended by 2 cycles, and latency SHALL grow by 2.
REQ-036 Without ACCEL_CHIP_SEQ_SYNC_EN, SAMPLE SHALL capture bit_out directly.

Structure
REQ-037 Package accel_chip_seq_pkg SHALL hold the op encoding enum (OP_PROG, OP_READ_MEM, OP_READ_REG, OP_INFER), the state enum and the idle instruction constant.
REQ-038 The block SHALL contain one sub-module, accel_chip_sync (parametrised-width 2-flop synchroniser), instantiated only under ACCEL_CHIP_SEQ_SYNC_EN.

Verification
REQ-039 Defaults, no sync, op 10, col 5, row 17, bit_out=4'b1010: CWL/CSL high cycles 3-6, rsp_valid at cycle 9, rsp_data=1010.
REQ-040 Op 11, wbit=1: CBLEN=CBL=CWL=CSL=1 for exactly 4 cycles; rsp_data=0000.
REQ-041 Op 01: no pulse line ever high; rsp_valid at cycle 5; a second cmd_valid during busy is ignored.
REQ-042 rsp_ready held low for 10 cycles: rsp_valid and rsp_data stay stable; cmd_ready=0 until the handshake completes.
REQ-043 Reset asserted in cycle 4 of op 10: the next edge gives all chip lines 0, instructions=01, no response.
REQ-044 ACCEL_CHIP_SEQ_SYNC_EN, op 00, HOLD_CYC=0: CSL high cycles 3-6, rsp_valid at cycle 10.

Source files
------------

// File: rtl/accel_chip_seq_pkg.sv
// ============================================================================
//  Module      : accel_chip_seq_pkg
//  Description : Op encodings, sequencer states and shared helpers for the
//                accelerator chip command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_chip_seq_pkg;

    typedef enum logic [1:0] {
        OP_INFER    = 2'b00,
        OP_READ_REG = 2'b01,
        OP_READ_MEM = 2'b10,
        OP_PROG     = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Instruction presented to the chip whenever no command is in flight
    localparam op_e c_IDLE_INSTR = OP_READ_REG;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/accel_chip_sync.sv
// ============================================================================
//  Module      : accel_chip_sync
//  Description : Parametrised-width two-flop synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_chip_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/accel_chip_seq.sv
// ============================================================================
//  Module      : accel_chip_seq
//  Description : Command sequencer driving SETUP/PULSE/HOLD/SAMPLE timing on
//                the accelerator chip lines. Define ACCEL_CHIP_SEQ_SYNC_EN to
//                synchronise bit_out through two flops (adds 2 hold cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_chip_seq
    import accel_chip_seq_pkg::*;
#(
    parameter int NARRAY    = 4,
    parameter int ADDR_W    = 5,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk_sys_in,
    input  logic              rst_sys_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_col,
    input  logic [ADDR_W-1:0] cmd_row,
    input  logic              cmd_wbit,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NARRAY-1:0] rsp_data,
    output logic              busy,
    output logic              CBL,
    output logic              CBLEN,
    output logic              CSL,
    output logic              CWL,
    output logic [1:0]        instructions,
    output logic [ADDR_W-1:0] addr_col,
    output logic [ADDR_W-1:0] addr_row,
    input  logic [NARRAY-1:0] bit_out
);

`ifdef ACCEL_CHIP_SEQ_SYNC_EN
    localparam int c_SYNC_EXTRA = 2;
`else
    localparam int c_SYNC_EXTRA = 0;
`endif

    localparam int c_HOLD_LEN = HOLD_CYC + c_SYNC_EXTRA;
    localparam int c_CNT_MAX  = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC + 2 + c_SYNC_EXTRA);
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    // Counter is loaded with (phase length - 1) and counts down to zero
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'((c_HOLD_LEN > 0) ? c_HOLD_LEN - 1 : 0);

    state_e              r_state;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_col;
    logic [ADDR_W-1:0]   r_row;
    logic                r_wbit;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_cbl;
    logic                r_cblen;
    logic                r_csl;
    logic                r_cwl;
    logic                r_rsp_valid;
    logic [NARRAY-1:0]   r_rsp_data;
    logic [NARRAY-1:0]   w_bit_src;

`ifdef ACCEL_CHIP_SEQ_SYNC_EN
    accel_chip_sync #(
        .WIDTH (NARRAY)
    ) u_sync (
        .clk (clk_sys_in),
        .rst (rst_sys_in),
        .i_d (bit_out),
        .o_q (w_bit_src)
    );
`else
    assign w_bit_src = bit_out;
`endif

    always_ff @(posedge clk_sys_in) begin
        if (rst_sys_in) begin
            r_state     <= ST_IDLE;
            r_op        <= c_IDLE_INSTR;
            r_col       <= '0;
            r_row       <= '0;
            r_wbit      <= 1'b0;
            r_cnt       <= '0;
            r_cbl       <= 1'b0;
            r_cblen     <= 1'b0;
            r_csl       <= 1'b0;
            r_cwl       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= op_e'(cmd_op);
                        r_col   <= cmd_col;
                        r_row   <= cmd_row;
                        r_wbit  <= cmd_wbit;
                        r_cnt   <= c_SETUP_LD;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        if (r_op != OP_READ_REG) begin
                            r_state <= ST_PULSE;
                            r_cnt   <= c_PULSE_LD;
                            r_csl   <= 1'b1;
                            r_cwl   <= (r_op == OP_PROG) || (r_op == OP_READ_MEM);
                            r_cblen <= (r_op == OP_PROG);
                            r_cbl   <= (r_op == OP_PROG) && r_wbit;
                        end else if (c_HOLD_LEN != 0) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= c_HOLD_LD;
                        end else begin
                            r_state <= ST_SAMPLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_csl   <= 1'b0;
                        r_cwl   <= 1'b0;
                        r_cblen <= 1'b0;
                        r_cbl   <= 1'b0;
                        if (c_HOLD_LEN != 0) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= c_HOLD_LD;
                        end else begin
                            r_state <= ST_SAMPLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    // A program operation has nothing to read back
                    r_rsp_data  <= (r_op == OP_PROG) ? '0 : w_bit_src;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_op        <= c_IDLE_INSTR;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign CBL          = r_cbl;
    assign CBLEN        = r_cblen;
    assign CSL          = r_csl;
    assign CWL          = r_cwl;
    assign instructions = r_op;
    assign addr_col     = r_col;
    assign addr_row     = r_row;

endmodule

`default_nettype wire

// File: tb/tb_accel_chip_seq.sv
// ============================================================================
//  Module      : tb_accel_chip_seq
//  Description : Directed self-checking bench for accel_chip_seq (defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_chip_seq;

    localparam int NARRAY = 4;
    localparam int ADDR_W = 5;
`ifdef ACCEL_CHIP_SEQ_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif
    // Defaults: SETUP 2 + PULSE 4 + HOLD 1 + 2, and 2 + 0 + 1 + 2 for read_reg
    localparam int LAT_PULSE = 9 + SYNC_EXTRA;
    localparam int LAT_REG   = 5 + SYNC_EXTRA;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_col;
    logic [ADDR_W-1:0] cmd_row;
    logic              cmd_wbit;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [NARRAY-1:0] rsp_data;
    logic              busy;
    logic              CBL, CBLEN, CSL, CWL;
    logic [1:0]        instructions;
    logic [ADDR_W-1:0] addr_col;
    logic [ADDR_W-1:0] addr_row;
    logic [NARRAY-1:0] bit_out;

    int checks = 0;
    int errors = 0;

    accel_chip_seq dut (
        .clk_sys_in   (clk),
        .rst_sys_in   (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_col      (cmd_col),
        .cmd_row      (cmd_row),
        .cmd_wbit     (cmd_wbit),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .CBL          (CBL),
        .CBLEN        (CBLEN),
        .CSL          (CSL),
        .CWL          (CWL),
        .instructions (instructions),
        .addr_col     (addr_col),
        .addr_row     (addr_row),
        .bit_out      (bit_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents a command in cycle 0; returns sampling in cycle 1
    task automatic start(input logic [1:0] op, input logic [ADDR_W-1:0] col,
                         input logic [ADDR_W-1:0] row, input logic wbit);
        cmd_op    = op;
        cmd_col   = col;
        cmd_row   = row;
        cmd_wbit  = wbit;
        cmd_valid = 1'b1;
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [20:0] got;
        rst = 1'b1;
        step;
        step;
        got = {CBL, CBLEN, CSL, CWL, instructions, addr_col, addr_row, rsp_valid, rsp_data, busy};
        checks++;
        if (got !== {4'b0000, 2'b01, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_during got %b expected %b", got,
                     {4'b0000, 2'b01, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0});
        end
        rst = 1'b0;
        step;
        checks++;
        if ({cmd_ready, busy, rsp_valid, CSL, CWL, instructions} !== 7'b1000001) begin
            errors++;
            $display("FAIL reset_after got %b expected %b",
                     {cmd_ready, busy, rsp_valid, CSL, CWL, instructions}, 7'b1000001);
        end
    endtask

    task automatic test_read_mem;
        bit_out   = 4'b1010;
        rsp_ready = 1'b1;
        start(2'b10, 5'd5, 5'd17, 1'b0);
        for (int c = 1; c <= LAT_PULSE + 1; c++) begin
            logic [6:0] exp_v, got_v;
            exp_v = {(c >= 3 && c <= 6), (c >= 3 && c <= 6), 1'b0, 1'b0,
                     (c == LAT_PULSE), (c <= LAT_PULSE), (c > LAT_PULSE)};
            got_v = {CWL, CSL, CBLEN, CBL, rsp_valid, busy, cmd_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL read_mem_lines cycle %0d got %b expected %b", c, got_v, exp_v);
            end
            if (c == LAT_PULSE) begin
                checks++;
                if ({instructions, addr_col, addr_row, rsp_data} !== {2'b10, 5'd5, 5'd17, 4'b1010}) begin
                    errors++;
                    $display("FAIL read_mem_data got %b expected %b",
                             {instructions, addr_col, addr_row, rsp_data},
                             {2'b10, 5'd5, 5'd17, 4'b1010});
                end
            end
            if (c <= LAT_PULSE) step;
        end
    endtask

    task automatic test_prog;
        int n_high;
        int n_cblen;
        int n_cbl;
        bit_out   = 4'b1111;
        rsp_ready = 1'b1;
        n_high    = 0;
        start(2'b11, 5'd1, 5'd2, 1'b1);
        for (int c = 1; c <= LAT_PULSE; c++) begin
            logic [5:0] exp_v, got_v;
            exp_v = {{4{(c >= 3 && c <= 6)}}, (c == LAT_PULSE), 1'b1};
            got_v = {CBLEN, CBL, CWL, CSL, rsp_valid, busy};
            if (CBLEN && CBL && CWL && CSL) n_high++;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL prog_lines cycle %0d got %b expected %b", c, got_v, exp_v);
            end
            if (c == LAT_PULSE) begin
                checks++;
                if (rsp_data !== 4'b0000) begin
                    errors++;
                    $display("FAIL prog_rsp_data got %b expected 0000", rsp_data);
                end
            end
            step;
        end
        checks++;
        if (n_high != 4) begin
            errors++;
            $display("FAIL prog_pulse_width got %0d expected 4", n_high);
        end
        // Programming a zero keeps CBL low while CBLEN still pulses
        n_cblen = 0;
        n_cbl   = 0;
        start(2'b11, 5'd3, 5'd4, 1'b0);
        for (int c = 1; c <= LAT_PULSE; c++) begin
            if (CBLEN) n_cblen++;
            if (CBL) n_cbl++;
            step;
        end
        checks++;
        if ({n_cblen, n_cbl} !== {32'd4, 32'd0}) begin
            errors++;
            $display("FAIL prog_wbit0 cblen %0d cbl %0d expected 4 and 0", n_cblen, n_cbl);
        end
    endtask

    task automatic test_read_reg;
        bit_out   = 4'b0110;
        rsp_ready = 1'b1;
        start(2'b01, 5'd7, 5'd8, 1'b0);
        for (int c = 1; c <= LAT_REG + 2; c++) begin
            logic [5:0] exp_v, got_v;
            exp_v = {4'b0000, (c == LAT_REG), (c <= LAT_REG)};
            got_v = {CWL, CSL, CBLEN, CBL, rsp_valid, busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL read_reg_lines cycle %0d got %b expected %b", c, got_v, exp_v);
            end
            if (c == LAT_REG) begin
                checks++;
                if ({instructions, addr_col, rsp_data} !== {2'b01, 5'd7, 4'b0110}) begin
                    errors++;
                    $display("FAIL read_reg_data got %b expected %b",
                             {instructions, addr_col, rsp_data}, {2'b01, 5'd7, 4'b0110});
                end
            end
            if (c == 2) begin
                cmd_op    = 2'b10;
                cmd_col   = 5'd31;
                cmd_valid = 1'b1;
            end
            if (c == 3) cmd_valid = 1'b0;
            step;
        end
    endtask

    task automatic test_backpressure;
        bit_out   = 4'b0011;
        rsp_ready = 1'b0;
        start(2'b10, 5'd9, 5'd10, 1'b0);
        for (int c = 1; c < LAT_PULSE; c++) step;
        checks++;
        if ({rsp_valid, rsp_data} !== 5'b10011) begin
            errors++;
            $display("FAIL bp_first got %b expected 10011", {rsp_valid, rsp_data});
        end
        bit_out   = 4'b1100;
        cmd_op    = 2'b11;
        cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step;
            checks++;
            if ({rsp_valid, rsp_data, cmd_ready, busy} !== 7'b1001101) begin
                errors++;
                $display("FAIL bp_hold wait %0d got %b expected 1001101", k,
                         {rsp_valid, rsp_data, cmd_ready, busy});
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step;
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release got %b expected 010", {rsp_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_reset_mid_pulse;
        logic [20:0] got;
        int          n_rsp;
        bit_out   = 4'b1001;
        rsp_ready = 1'b1;
        start(2'b10, 5'd5, 5'd17, 1'b0);
        step;
        step;
        step;
        checks++;
        if ({CWL, CSL} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pulse_active got %b expected 11", {CWL, CSL});
        end
        rst = 1'b1;
        step;
        got = {CBL, CBLEN, CSL, CWL, instructions, addr_col, addr_row, rsp_valid, rsp_data, busy};
        checks++;
        if (got !== {4'b0000, 2'b01, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL mid_pulse_reset got %b expected %b", got,
                     {4'b0000, 2'b01, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0});
        end
        rst   = 1'b0;
        n_rsp = 0;
        for (int k = 0; k < 15; k++) begin
            step;
            if (rsp_valid || busy || !cmd_ready) n_rsp++;
        end
        checks++;
        if (n_rsp != 0) begin
            errors++;
            $display("FAIL mid_pulse_no_resp got %0d active cycles expected 0", n_rsp);
        end
    endtask

    task automatic test_back_to_back;
        bit_out   = 4'b0101;
        rsp_ready = 1'b1;
        start(2'b00, 5'd3, 5'd9, 1'b1);
        for (int c = 1; c <= LAT_PULSE + 1; c++) begin
            logic [5:0] exp_v, got_v;
            exp_v = {1'b0, (c >= 3 && c <= 6), 1'b0, 1'b0, (c == LAT_PULSE), (c <= LAT_PULSE)};
            got_v = {CWL, CSL, CBLEN, CBL, rsp_valid, busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL infer_lines cycle %0d got %b expected %b", c, got_v, exp_v);
            end
            if (c == LAT_PULSE) begin
                checks++;
                if ({instructions, rsp_data} !== {2'b00, 4'b0101}) begin
                    errors++;
                    $display("FAIL infer_data got %b expected 000101", {instructions, rsp_data});
                end
            end
            if (c <= LAT_PULSE) step;
        end
        bit_out = 4'b1110;
        start(2'b01, 5'd2, 5'd6, 1'b0);
        for (int c = 1; c < LAT_REG; c++) step;
        checks++;
        if ({rsp_valid, rsp_data, addr_row} !== {1'b1, 4'b1110, 5'd6}) begin
            errors++;
            $display("FAIL b2b_second got %b expected %b", {rsp_valid, rsp_data, addr_row},
                     {1'b1, 4'b1110, 5'd6});
        end
        step;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_col   = '0;
        cmd_row   = '0;
        cmd_wbit  = 1'b0;
        rsp_ready = 1'b1;
        bit_out   = '0;
        test_reset;
        test_read_mem;
        test_prog;
        test_read_reg;
        test_backpressure;
        test_reset_mid_pulse;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
